gpio_mmio: RTL and testbench
============================

Name: gpio_mmio

Overview:
- Parametrised memory-mapped GPIO peripheral for the Hack CPU data bus; the successor to the fixed two-LED/two-button map.
- Provides WIDTH bidirectional pins with a direction register, synchronised and debounced inputs, and per-pin rising/falling edge capture.
- Edge capture uses sticky write-1-to-clear flags and a level interrupt output.
- Sits beside data RAM; the top-level read mux selects rdata when hit_r=1.

Parameters:
- WIDTH, 8, number of GPIO pins (1..16); register bits above WIDTH-1 read 0 and ignore writes.
- BASE, 16'h2000, base word address of the 8-word register window; must be 8-aligned.
- DB_DIV, 100000, debounce sample period in clk cycles (>=1); 100000 = 1 ms at 100 MHz.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- addr_r  in  16  data read address (addressMR of cpu)
- addr_w  in  16  data write address (addressMW of cpu)
- wdata  in  16  write data (outM of cpu)
- we  in  1  write strobe (writeM of cpu)
- rdata  out  16  combinational read data; 0 when hit_r=0
- hit_r  out  1  addr_r[15:3]==BASE[15:3]
- pin_in  in  WIDTH  raw asynchronous pin inputs
- pin_out  out  WIDTH  output data, equal to the OUT register
- pin_oe  out  WIDTH  output enable, equal to the DIR register (1 = drive)
- irq  out  1  |EDGE, driven from registers

Behaviour:
- Register offsets (address minus BASE):
  - 0 OUT: R/W.
  - 1 IN: R, debounced input; write ignored.
  - 2 DIR: R/W.
  - 3 EDGE: R; write 1 to clear a bit.
  - 4 RISE_EN: R/W.
  - 5 FALL_EN: R/W.
  - 6, 7: read 0; writes ignored.
- Writes:
  - Take effect at the posedge where we=1 and addr_w is in the window; reads see the new value the next cycle.
  - Only wdata[WIDTH-1:0] is used.
- Reads:
  - Purely combinational from addr_r, with zero latency, matching the Hack single-cycle read.
  - Read data is zero-extended to 16 bits.
  - Reads have no side effects.
- Reset (rstn=0 at posedge) clears OUT, DIR, EDGE, RISE_EN, FALL_EN, all synchroniser/sample/debounce registers, the previous-debounce register and the prescaler.
  - Consequently pin_out=0, pin_oe=0, irq=0.
  - Reset mid-debounce discards any pending sample.
- Input path, per bit, every posedge:
  - sync1<=pin_in; sync2<=sync1.
- Prescaler:
  - Counts 0..DB_DIV-1 and wraps.
  - tick=1 when the count equals DB_DIV-1; with DB_DIV=1, tick=1 every cycle.
- On tick:
  - samp<=sync2.
  - For each bit where sync2==samp, deb<=sync2; other bits hold.
  - A new level is therefore accepted only after two consecutive tick samples agree.
  - Any pulse shorter than DB_DIV cycles is rejected.
- Latency: with DB_DIV=1, a pin_in change set up before posedge N appears in IN after posedge N+3.
- Edge detect, every posedge:
  - deb_prev<=deb.
  - rise=deb&~deb_prev; fall=~deb&deb_prev.
  - EDGE<=(EDGE & ~clr) | (rise&RISE_EN) | (fall&FALL_EN), where clr=wdata[WIDTH-1:0] on a write to offset 3, else 0.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Edges on pins with the enable bit 0 are never recorded.
  - Enabling a pin later does not retroactively flag past edges.
- irq=|EDGE, asserted the cycle after the flag sets and deasserted the cycle after the last flag clears.
- IN reflects the pin level regardless of DIR, so output pins read back their external level.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with pin_in=8'hFF -> pin_out=0, pin_oe=0, irq=0, all registers read 0; after release with DB_DIV=1, IN=8'hFF at the 4th posedge and EDGE stays 0 (enables 0).
- R/W: write OUT=16'hFFA5 and DIR=16'h000F -> pin_out=8'hA5, pin_oe=8'h0F, OUT reads 16'h00A5; a read of BASE+6 returns 0; a read of BASE+8 gives hit_r=0 and rdata=0.
- Debounce with DB_DIV=4:
  - Bit0 high pulse of 3 cycles -> IN bit0 never sets.
  - Bit0 held high -> IN bit0=1 within 2+2*4 cycles.
- Edge/irq:
  - RISE_EN=1, FALL_EN=2; bit0 rises -> EDGE=1, irq=1 one cycle later.
  - Bit1 falls -> EDGE=3.
  - Write EDGE=1 -> EDGE=2, irq stays 1; write 2 -> irq=0.
- Set-wins collision: W1C of bit0 in the same cycle as a new bit0 rise -> EDGE bit0 remains 1.
- Reset mid-operation: assert rstn=0 while EDGE=3 and a debounce is in progress -> EDGE=0, irq=0 the next cycle; the debounce restarts from 0.

Source files
------------

// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped GPIO for the Hack CPU data bus.
// WIDTH bidirectional pins with direction control, synchronised and debounced
// inputs, per-pin rising/falling edge capture with sticky W1C flags and a
// level interrupt.
//
// Ports:
//   clk, rstn      system clock, synchronous active-low reset
//   addr_r         read word address (combinational read path)
//   addr_w, wdata  write word address and data, qualified by we
//   rdata, hit_r   read data (0 outside the window) and window hit
//   pin_in         raw asynchronous pin levels
//   pin_out        OUT register
//   pin_oe         DIR register (1 = drive)
//   irq            registered OR of the EDGE flags
//
// Register map (word offset from BASE):
//   0 OUT R/W, 1 IN R, 2 DIR R/W, 3 EDGE R/W1C, 4 RISE_EN R/W, 5 FALL_EN R/W,
//   6/7 read 0.
module gpio_mmio #(
  parameter int unsigned WIDTH  = 8,
  parameter logic [15:0] BASE   = 16'h2000,
  parameter int unsigned DB_DIV = 100000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [15:0]      addr_r,
  input  logic [15:0]      addr_w,
  input  logic [15:0]      wdata,
  input  logic             we,
  output logic [15:0]      rdata,
  output logic             hit_r,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  localparam int unsigned CW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;

  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_IN   = 3'd1;
  localparam logic [2:0] OFF_DIR  = 3'd2;
  localparam logic [2:0] OFF_EDGE = 3'd3;
  localparam logic [2:0] OFF_REN  = 3'd4;
  localparam logic [2:0] OFF_FEN  = 3'd5;

  logic [WIDTH-1:0] out_q, dir_q, edge_q, rise_en_q, fall_en_q;
  logic [WIDTH-1:0] sync1_q, sync2_q, samp_q, deb_q, deb_prev_q;
  logic [CW-1:0]    cnt_q;
  logic             irq_q;

  logic             wr;
  logic [2:0]       woff;
  logic [WIDTH-1:0] wval;
  logic             tick;
  logic [WIDTH-1:0] rise, fall, clr, edge_d, agree;

  // Upper write-data bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Write decode, prescaler tick and edge-flag next state.
  always_comb begin
    wr     = we && (addr_w[15:3] == BASE[15:3]);
    woff   = addr_w[2:0];
    wval   = wdata[WIDTH-1:0];
    tick   = (cnt_q == CW'(DB_DIV - 1));
    agree  = ~(sync2_q ^ samp_q);
    rise   = deb_q & ~deb_prev_q;
    fall   = ~deb_q & deb_prev_q;
    clr    = (wr && (woff == OFF_EDGE)) ? wval : '0;
    // Set terms are OR-ed after the clear so a simultaneous set wins.
    edge_d = (edge_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  // Input synchroniser, debounce prescaler and edge capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      samp_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      edge_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= pin_in;
      sync2_q    <= sync1_q;
      cnt_q      <= tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        samp_q <= sync2_q;
        // Accept a level only once two consecutive tick samples match.
        deb_q  <= (deb_q & ~agree) | (sync2_q & agree);
      end
      deb_prev_q <= deb_q;
      edge_q     <= edge_d;
      irq_q      <= |edge_q;
    end
  end

  // Software-writable control registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr) begin
      case (woff)
        OFF_OUT: out_q     <= wval;
        OFF_DIR: dir_q     <= wval;
        OFF_REN: rise_en_q <= wval;
        OFF_FEN: fall_en_q <= wval;
        default: ;
      endcase
    end
  end

  // Zero-latency read mux, zero-extended, no side effects.
  always_comb begin
    hit_r = (addr_r[15:3] == BASE[15:3]);
    rdata = '0;
    if (hit_r) begin
      case (addr_r[2:0])
        OFF_OUT:  rdata = 16'(out_q);
        OFF_IN:   rdata = 16'(deb_q);
        OFF_DIR:  rdata = 16'(dir_q);
        OFF_EDGE: rdata = 16'(edge_q);
        OFF_REN:  rdata = 16'(rise_en_q);
        OFF_FEN:  rdata = 16'(fall_en_q);
        default:  rdata = '0;
      endcase
    end
  end

  assign pin_out = out_q;
  assign pin_oe  = dir_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// Testbench for gpio_mmio: two instances (DB_DIV=1 and DB_DIV=4) share one
// bus and are checked every cycle against a behavioural model, plus directed
// scenarios with hand-computed expectations.
module tb_gpio_mmio;

  localparam logic [15:0] BASE = 16'h2000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] addr_r, addr_w, wdata;
  logic        we;
  logic [7:0]  pin_in;

  logic [15:0] rdata_a, rdata_b;
  logic        hit_a, hit_b, irq_a, irq_b;
  logic [7:0]  pout_a, pout_b, poe_a, poe_b;

  gpio_mmio #(.WIDTH(8), .BASE(BASE), .DB_DIV(1)) u_a (
    .clk(clk), .rstn(rstn), .addr_r(addr_r), .addr_w(addr_w), .wdata(wdata),
    .we(we), .rdata(rdata_a), .hit_r(hit_a), .pin_in(pin_in),
    .pin_out(pout_a), .pin_oe(poe_a), .irq(irq_a));

  gpio_mmio #(.WIDTH(8), .BASE(BASE), .DB_DIV(4)) u_b (
    .clk(clk), .rstn(rstn), .addr_r(addr_r), .addr_w(addr_w), .wdata(wdata),
    .we(we), .rdata(rdata_b), .hit_r(hit_b), .pin_in(pin_in),
    .pin_out(pout_b), .pin_oe(poe_b), .irq(irq_b));

  always #10 clk = ~clk;

  // Behavioural model state.
  typedef struct packed {
    logic [7:0]  outr, dir, edg, ren, fen;
    logic [7:0]  s1, s2, samp, deb, prev;
    logic        irq;
    logic [31:0] phase;
  } mst_t;

  mst_t ma, mb;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_on = 1'b0;

  function automatic mst_t step(input mst_t m, input int div, input logic rs,
                                input logic [7:0] pin, input logic wen,
                                input logic [15:0] aw, input logic [15:0] wd);
    mst_t n;
    logic [7:0] clr;
    logic       hitw;
    n = m;
    if (!rs) begin
      n = '0;
      return n;
    end
    n.s1 = pin;
    n.s2 = m.s1;
    n.phase = (m.phase + 1) % div;
    if (m.phase == 32'(div - 1)) begin
      n.samp = m.s2;
      for (int i = 0; i < 8; i++)
        if (m.s2[i] == m.samp[i]) n.deb[i] = m.s2[i];
    end
    n.prev = m.deb;
    hitw = wen && (aw[15:3] == BASE[15:3]);
    clr = (hitw && aw[2:0] == 3'd3) ? wd[7:0] : 8'h00;
    n.edg = m.edg & ~clr;
    for (int i = 0; i < 8; i++) begin
      if (m.deb[i] && !m.prev[i] && m.ren[i]) n.edg[i] = 1'b1;
      if (!m.deb[i] && m.prev[i] && m.fen[i]) n.edg[i] = 1'b1;
    end
    n.irq = (m.edg != 8'h00);
    if (hitw) begin
      case (aw[2:0])
        3'd0: n.outr = wd[7:0];
        3'd2: n.dir  = wd[7:0];
        3'd4: n.ren  = wd[7:0];
        3'd5: n.fen  = wd[7:0];
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [15:0] mread(input mst_t m, input logic [15:0] a);
    if (a[15:3] != BASE[15:3]) return 16'h0000;
    case (a[2:0])
      3'd0: return {8'h00, m.outr};
      3'd1: return {8'h00, m.deb};
      3'd2: return {8'h00, m.dir};
      3'd3: return {8'h00, m.edg};
      3'd4: return {8'h00, m.ren};
      3'd5: return {8'h00, m.fen};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma <= step(ma, 1, rstn, pin_in, we, addr_w, wdata);
    mb <= step(mb, 4, rstn, pin_in, we, addr_w, wdata);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("a.pin_out", 16'(pout_a), 16'(ma.outr));
      check("a.pin_oe",  16'(poe_a),  16'(ma.dir));
      check("a.irq",     16'(irq_a),  16'(ma.irq));
      check("a.hit_r",   16'(hit_a),  16'(addr_r[15:3] == BASE[15:3]));
      check("a.rdata",   rdata_a,     mread(ma, addr_r));
      check("b.pin_out", 16'(pout_b), 16'(mb.outr));
      check("b.pin_oe",  16'(poe_b),  16'(mb.dir));
      check("b.irq",     16'(irq_b),  16'(mb.irq));
      check("b.hit_r",   16'(hit_b),  16'(addr_r[15:3] == BASE[15:3]));
      check("b.rdata",   rdata_b,     mread(mb, addr_r));
    end
  end

  task automatic next(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string name, input bit inst_b, input logic [2:0] off,
                    input logic [15:0] exp);
    addr_r = BASE + 16'(off);
    #1;
    check(name, inst_b ? rdata_b : rdata_a, exp);
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d);
    we = 1'b1;
    addr_w = BASE + 16'(off);
    wdata = d;
    next();
    we = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; pin_in = 8'hFF; we = 1'b0;
    addr_r = BASE; addr_w = 16'h0000; wdata = 16'h0000;

    // Reset with all pins high.
    next();
    chk_on = 1'b1;
    next();
    check("rst.pin_out", 16'(pout_a), 16'h0000);
    check("rst.pin_oe",  16'(poe_a),  16'h0000);
    check("rst.irq",     16'(irq_a),  16'h0000);
    for (int i = 0; i < 8; i++) rd("rst.read", 1'b0, 3'(i), 16'h0000);
    rstn = 1'b1;
    next(3);
    rd("rst.in_3", 1'b0, 3'd1, 16'h0000);
    next();
    rd("rst.in_4", 1'b0, 3'd1, 16'h00FF);
    next(2);
    rd("rst.edge", 1'b0, 3'd3, 16'h0000);

    // Register read/write.
    wr(3'd0, 16'hFFA5);
    wr(3'd2, 16'h000F);
    check("rw.pin_out", 16'(pout_a), 16'h00A5);
    check("rw.pin_oe",  16'(poe_a),  16'h000F);
    rd("rw.out", 1'b0, 3'd0, 16'h00A5);
    rd("rw.off6", 1'b0, 3'd6, 16'h0000);
    addr_r = BASE + 16'd8;
    #1;
    check("rw.hit8", 16'(hit_a), 16'h0000);
    check("rw.rd8", rdata_a, 16'h0000);

    // Edge capture and interrupt.
    pin_in = 8'hFE;
    next(6);
    wr(3'd4, 16'h0001);
    wr(3'd5, 16'h0002);
    pin_in = 8'hFF;
    next(5);
    rd("edge.rise0", 1'b0, 3'd3, 16'h0001);
    next();
    check("edge.irq1", 16'(irq_a), 16'h0001);
    pin_in = 8'hFD;
    next(5);
    rd("edge.fall1", 1'b0, 3'd3, 16'h0003);
    wr(3'd3, 16'h0001);
    rd("edge.w1c1", 1'b0, 3'd3, 16'h0002);
    check("edge.irq_hold", 16'(irq_a), 16'h0001);
    wr(3'd3, 16'h0002);
    rd("edge.w1c2", 1'b0, 3'd3, 16'h0000);
    next();
    check("edge.irq_clr", 16'(irq_a), 16'h0000);

    // Clear and set of the same bit in one cycle.
    pin_in = 8'hFC;
    next(6);
    pin_in = 8'hFD;
    next(4);
    wr(3'd3, 16'h0001);
    rd("collide.set_wins", 1'b0, 3'd3, 16'h0001);
    wr(3'd3, 16'h0001);
    rd("collide.clr", 1'b0, 3'd3, 16'h0000);

    // Debounce on the DB_DIV=4 instance.
    pin_in = 8'hFC;
    next(20);
    rd("db.low", 1'b1, 3'd1, 16'h00FC);
    pin_in = 8'hFD;
    next(3);
    pin_in = 8'hFC;
    for (int i = 0; i < 20; i++) begin
      next();
      addr_r = BASE + 16'd1;
      #1;
      check("db.pulse_rejected", 16'(rdata_b[0]), 16'h0000);
    end
    pin_in = 8'hFD;
    next(10);
    rd("db.accepted", 1'b1, 3'd1, 16'h00FD);

    // Reset in the middle of activity.
    pin_in = 8'hFE;
    next(6);
    wr(3'd3, 16'h0003);
    pin_in = 8'hFD;
    next(5);
    rd("mid.edge3", 1'b0, 3'd3, 16'h0003);
    pin_in = 8'hFE;
    next(2);
    rstn = 1'b0;
    next();
    rd("mid.edge0", 1'b0, 3'd3, 16'h0000);
    rd("mid.in0", 1'b0, 3'd1, 16'h0000);
    check("mid.irq", 16'(irq_a), 16'h0000);
    check("mid.pin_oe", 16'(poe_a), 16'h0000);
    rstn = 1'b1;
    next(3);
    rd("mid.in_3", 1'b0, 3'd1, 16'h0000);
    next();
    rd("mid.in_4", 1'b0, 3'd1, 16'h00FE);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) pin_in = pin_in ^ 8'($urandom);
      we     = ($urandom_range(0, 2) == 0);
      addr_w = ($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 7));
      wdata  = 16'($urandom);
      addr_r = ($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 7));
      rstn   = ($urandom_range(0, 299) != 0);
      next();
    end
    we = 1'b0;
    rstn = 1'b1;
    next(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
